// File: rtl/game_round_controller.sv
// rtl/game_round_controller.sv - multi-round countdown game sequencer with seconds prescaler
// Optional BONUS_TIME_EN: every 10th point scored in RUN adds 5 seconds to TimeLeft.
module game_round_controller #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int ROUND_SECONDS = 30,
  parameter int NUM_ROUNDS    = 3
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Start,
  input  logic       i_Pause,
  input  logic       i_Hit,
  output logic [7:0] o_TimeLeft,
  output logic [7:0] o_Score,
  output logic [7:0] o_HighScore,
  output logic [1:0] o_Round,
  output logic       o_Busy,
  output logic       o_RoundDone,
  output logic       o_GameOver
);

  localparam logic [26:0] TERM_COUNT = 27'(TICKS_PER_SEC - 1);
  localparam logic [7:0]  RELOAD     = 8'(ROUND_SECONDS);
  localparam logic [1:0]  LAST_ROUND = 2'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PAUSE,
    ROUND_END,
    GAME_OVER
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [26:0] r_prescale, w_prescale_nxt;
  logic [7:0]  r_time, w_time_nxt;
  logic [7:0]  r_score, w_score_nxt;
  logic [7:0]  r_high, w_high_nxt;
  logic [1:0]  r_round, w_round_nxt;
  logic        r_start_q;
  logic        r_busy, w_busy_nxt;
  logic        r_round_done, w_round_done_nxt;
  logic        r_game_over, w_game_over_nxt;
  logic        w_start_edge;
  logic        w_tick;
  logic        w_hit_ok;
  logic [7:0]  w_time_run;

  assign w_start_edge = i_Start & ~r_start_q;
  assign w_hit_ok     = i_Hit && (r_score != 8'd255);

  always_comb begin
    w_state_nxt    = r_state;
    w_prescale_nxt = r_prescale;
    w_time_nxt     = r_time;
    w_score_nxt    = r_score;
    w_high_nxt     = r_high;
    w_round_nxt    = r_round;
    w_tick         = 1'b0;
    w_time_run     = r_time;

    case (r_state)
      IDLE, GAME_OVER: begin
        if (w_start_edge) begin
          w_state_nxt    = RUN;
          w_score_nxt    = 8'd0;
          w_round_nxt    = 2'd1;
          w_time_nxt     = RELOAD;
          w_prescale_nxt = 27'd0;
        end
      end

      RUN: begin
        if (r_prescale == TERM_COUNT) begin
          w_tick         = 1'b1;
          w_prescale_nxt = 27'd0;
        end else begin
          w_prescale_nxt = r_prescale + 27'd1;
        end
        if (w_hit_ok) begin
          w_score_nxt = r_score + 8'd1;
        end
        w_time_run = w_tick ? (r_time - 8'd1) : r_time;
`ifdef BONUS_TIME_EN
        // Bonus is folded in after the tick so a coinciding tick yields TimeLeft-1+5.
        if (w_hit_ok && (((r_score + 8'd1) % 8'd10) == 8'd0)) begin
          w_time_run = (w_time_run > 8'd94) ? 8'd99 : (w_time_run + 8'd5);
        end
`endif
        w_time_nxt = w_time_run;
        if (w_tick && (w_time_run == 8'd0)) begin
          w_state_nxt = ROUND_END;
        end else if (i_Pause) begin
          w_state_nxt = PAUSE;
        end
      end

      PAUSE: begin
        if (!i_Pause) begin
          w_state_nxt = RUN;
        end
      end

      ROUND_END: begin
        if (r_round == LAST_ROUND) begin
          w_state_nxt = GAME_OVER;
          if (r_score > r_high) begin
            w_high_nxt = r_score;
          end
        end else begin
          w_state_nxt    = RUN;
          w_round_nxt    = r_round + 2'd1;
          w_time_nxt     = RELOAD;
          w_prescale_nxt = 27'd0;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt       = (w_state_nxt == RUN) || (w_state_nxt == PAUSE) ||
                       (w_state_nxt == ROUND_END);
    w_round_done_nxt = (w_state_nxt == ROUND_END);
    w_game_over_nxt  = (w_state_nxt == GAME_OVER);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state      <= IDLE;
      r_prescale   <= 27'd0;
      r_time       <= RELOAD;
      r_score      <= 8'd0;
      r_high       <= 8'd0;
      r_round      <= 2'd0;
      r_start_q    <= 1'b1;
      r_busy       <= 1'b0;
      r_round_done <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prescale   <= w_prescale_nxt;
      r_time       <= w_time_nxt;
      r_score      <= w_score_nxt;
      r_high       <= w_high_nxt;
      r_round      <= w_round_nxt;
      r_start_q    <= i_Start;
      r_busy       <= w_busy_nxt;
      r_round_done <= w_round_done_nxt;
      r_game_over  <= w_game_over_nxt;
    end
  end

  assign o_TimeLeft  = r_time;
  assign o_Score     = r_score;
  assign o_HighScore = r_high;
  assign o_Round     = r_round;
  assign o_Busy      = r_busy;
  assign o_RoundDone = r_round_done;
  assign o_GameOver  = r_game_over;

endmodule

// File: tb/tb_game_round_controller.sv
// tb/tb_game_round_controller.sv - self-checking bench for game_round_controller
// Works with BONUS_TIME_EN defined or undefined.
module tb_game_round_controller;

  logic       clk = 1'b0;
  logic       i_Reset, i_Start, i_Pause, i_Hit;
  logic [7:0] o_TimeLeft, o_Score, o_HighScore;
  logic [1:0] o_Round;
  logic       o_Busy, o_RoundDone, o_GameOver;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  game_round_controller #(
    .TICKS_PER_SEC(4),
    .ROUND_SECONDS(3),
    .NUM_ROUNDS   (2)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (i_Reset),
    .i_Start    (i_Start),
    .i_Pause    (i_Pause),
    .i_Hit      (i_Hit),
    .o_TimeLeft (o_TimeLeft),
    .o_Score    (o_Score),
    .o_HighScore(o_HighScore),
    .o_Round    (o_Round),
    .o_Busy     (o_Busy),
    .o_RoundDone(o_RoundDone),
    .o_GameOver (o_GameOver)
  );

  typedef struct {
    int tl, sc, rnd, bz, rd, go, hs;
  } exp_t;

  typedef struct {
    logic st, pa, hi;
    exp_t e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic add(input logic st, pa, hi, input int tl, sc, rnd, bz, rd, go, hs);
    vec_t v;
    v.st = st; v.pa = pa; v.hi = hi;
    v.e.tl = tl; v.e.sc = sc; v.e.rnd = rnd; v.e.bz = bz;
    v.e.rd = rd; v.e.go = go; v.e.hs = hs;
    vecs.push_back(v);
  endtask

  task automatic step(input logic st, pa, hi);
    i_Start = st; i_Pause = pa; i_Hit = hi;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".TimeLeft"}, int'(o_TimeLeft), e.tl);
    chk({tag, ".Score"}, int'(o_Score), e.sc);
    chk({tag, ".Round"}, int'(o_Round), e.rnd);
    chk({tag, ".Busy"}, int'(o_Busy), e.bz);
    chk({tag, ".RoundDone"}, int'(o_RoundDone), e.rd);
    chk({tag, ".GameOver"}, int'(o_GameOver), e.go);
    chk({tag, ".HighScore"}, int'(o_HighScore), e.hs);
  endtask

  task automatic do_reset();
    i_Reset = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    i_Reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t e;
    int   found;
    i_Reset = 1'b1; i_Start = 1'b0; i_Pause = 1'b0; i_Hit = 1'b0;

    // Game 1: rows are inputs for one cycle, expectations are outputs in the following cycle.
    add(1,0,0, 3,0,1,1,0,0,0);
    add(0,0,1, 3,1,1,1,0,0,0);
    add(1,0,1, 3,2,1,1,0,0,0);
    add(0,0,1, 3,3,1,1,0,0,0);
    add(0,0,1, 2,4,1,1,0,0,0);
    add(0,0,1, 2,5,1,1,0,0,0);
    add(0,0,0, 2,5,1,1,0,0,0);
    add(0,0,0, 2,5,1,1,0,0,0);
    add(0,0,0, 1,5,1,1,0,0,0);
    add(0,0,0, 1,5,1,1,0,0,0);
    add(0,0,0, 1,5,1,1,0,0,0);
    add(0,0,0, 1,5,1,1,0,0,0);
    add(0,0,0, 0,5,1,1,1,0,0);
    add(0,0,0, 3,5,2,1,0,0,0);
    add(0,0,1, 3,6,2,1,0,0,0);
    add(0,0,1, 3,7,2,1,0,0,0);
    add(0,0,0, 3,7,2,1,0,0,0);
    add(0,0,0, 2,7,2,1,0,0,0);
    add(0,0,0, 2,7,2,1,0,0,0);
    add(0,0,0, 2,7,2,1,0,0,0);
    add(0,0,0, 2,7,2,1,0,0,0);
    add(0,0,0, 1,7,2,1,0,0,0);
    add(0,0,0, 1,7,2,1,0,0,0);
    add(0,0,0, 1,7,2,1,0,0,0);
    add(0,0,0, 1,7,2,1,0,0,0);
    add(0,0,1, 0,8,2,1,1,0,0);
    add(0,0,0, 0,8,2,0,0,1,8);
    add(0,0,1, 0,8,2,0,0,1,8);

    do_reset();
    e = '{tl:3, sc:0, rnd:0, bz:0, rd:0, go:0, hs:0};
    chk_all("reset", e);

    for (int i = 0; i < vecs.size(); i++) begin
      sb.push_back(vecs[i].e);
      step(vecs[i].st, vecs[i].pa, vecs[i].hi);
      e = sb.pop_front();
      chk_all($sformatf("game1[%0d]", i), e);
    end

    // Game 2: lower score must not replace the high score.
    step(1'b1, 1'b0, 1'b0);
    chk("g2.Busy", int'(o_Busy), 1);
    chk("g2.Score_clr", int'(o_Score), 0);
    chk("g2.GameOver_clr", int'(o_GameOver), 0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    found = 0;
    for (int k = 0; k < 60 && found == 0; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (o_GameOver) found = 1;
    end
    chk("g2.reach_gameover", found, 1);
    chk("g2.Score", int'(o_Score), 2);
    chk("g2.HighScore", int'(o_HighScore), 8);
    chk("g2.Round", int'(o_Round), 2);

    // Reset mid-RUN with Start held through and after reset.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk("g3.Score", int'(o_Score), 1);
    i_Reset = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    i_Reset = 1'b0;
    e = '{tl:3, sc:0, rnd:0, bz:0, rd:0, go:0, hs:0};
    chk_all("midreset", e);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("held_start.Busy", int'(o_Busy), 0);
      chk("held_start.Round", int'(o_Round), 0);
    end
    step(1'b0, 1'b0, 1'b0);

    // Pause after two counted cycles of a second, with a coinciding hit.
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    chk("pause.hit_counted", int'(o_Score), 1);
    for (int k = 0; k < 9; k++) begin
      step(1'b0, 1'b1, 1'b1);
      chk("pause.TimeLeft_frozen", int'(o_TimeLeft), 3);
      chk("pause.hit_ignored", int'(o_Score), 1);
    end
    step(1'b0, 1'b0, 1'b0);
    chk("resume.+1", int'(o_TimeLeft), 3);
    step(1'b0, 1'b0, 1'b0);
    chk("resume.+2", int'(o_TimeLeft), 3);
    step(1'b0, 1'b0, 1'b0);
    chk("resume.+3_decrement", int'(o_TimeLeft), 2);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b0);
    chk("pre_final.TimeLeft", int'(o_TimeLeft), 1);
    step(1'b0, 1'b1, 1'b0);
    chk("final_pause.RoundDone", int'(o_RoundDone), 1);
    chk("final_pause.TimeLeft", int'(o_TimeLeft), 0);
    step(1'b0, 1'b1, 1'b0);
    chk("final_pause.Round", int'(o_Round), 2);
    chk("final_pause.reload", int'(o_TimeLeft), 3);
    chk("final_pause.RoundDone_clr", int'(o_RoundDone), 0);
    step(1'b0, 1'b0, 1'b0);

    // Tenth hit lands while TimeLeft=2 at the start of a second.
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 1'b1);
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      if (o_Round == 2'd2 && o_TimeLeft == 8'd2) found = 1;
      else step(1'b0, 1'b0, 1'b0);
    end
    chk("bonus.reach", found, 1);
    step(1'b0, 1'b0, 1'b1);
    chk("bonus.Score", int'(o_Score), 10);
`ifdef BONUS_TIME_EN
    chk("bonus.TimeLeft", int'(o_TimeLeft), 7);
`else
    chk("bonus.TimeLeft", int'(o_TimeLeft), 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
